// File: rtl/abnormality_report_tx_if.sv
// rtl/abnormality_report_tx_if.sv - abnormality snapshot inputs and serial report link
interface abnormality_report_tx_if;
    logic [5:0] abnormaliryVector;
    logic [2:0] abnormaliryWarning;
    logic [6:0] dataP;
    logic [6:0] dataQ;
    logic       txConfirm;
    logic       txRequest;
    logic       txData;
    logic       busy;
    logic       frameSent;
    logic       linkFail;

    // Reporter side: watches the healthcare outputs and drives the serial link.
    modport master (
        input  abnormaliryVector,
        input  abnormaliryWarning,
        input  dataP,
        input  dataQ,
        input  txConfirm,
        output txRequest,
        output txData,
        output busy,
        output frameSent,
        output linkFail
    );

    // Source/receiver side: supplies the healthcare outputs and the confirm.
    modport slave (
        output abnormaliryVector,
        output abnormaliryWarning,
        output dataP,
        output dataQ,
        output txConfirm,
        input  txRequest,
        input  txData,
        input  busy,
        input  frameSent,
        input  linkFail
    );
endinterface

// File: rtl/abnormality_report_tx.sv
// rtl/abnormality_report_tx.sv - serialises abnormality changes into parity-protected frames with retry
module abnormality_report_tx #(
    parameter int TIMEOUT = 16,
    parameter int RETRIES = 2
) (
    input logic                     clock,
    input logic                     reset,
    abnormality_report_tx_if.master bus
);
    localparam int WaitWidth    = $clog2(TIMEOUT + 1);
    localparam int AttemptWidth = $clog2(RETRIES + 2);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, DONE, FAIL} stateT;

    stateT                   state;
    stateT                   nextState;
    logic [22:0]             payload;
    logic [23:0]             liveFrame;
    logic [23:0]             snapFrame;
    logic [23:0]             shiftReg;
    logic [23:0]             shiftNext;
    logic [4:0]              bitCnt;
    logic [WaitWidth-1:0]    waitCnt;
    logic [AttemptWidth-1:0] attempt;
    logic [5:0]              lastVector;
    logic                    timeoutHit;

    // Even parity in bit 0 makes the XOR over the whole frame zero.
    assign payload    = {bus.abnormaliryVector, bus.abnormaliryWarning, bus.dataP, bus.dataQ};
    assign liveFrame  = {payload, ^payload};
    assign timeoutHit = (waitCnt == WaitWidth'(TIMEOUT - 1));

    // State register; reset aborts any frame in progress immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and next shift-register contents; retries reload from the held snapshot.
    always_comb begin
        nextState = state;
        shiftNext = shiftReg;
        case (state)
            IDLE: begin
                if (bus.abnormaliryVector != lastVector) begin
                    nextState = SEND;
                    shiftNext = liveFrame;
                end
            end
            SEND: begin
                shiftNext = {shiftReg[22:0], 1'b0};
                if (bitCnt == 5'd23) begin
                    nextState = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.txConfirm) begin
                    nextState = DONE;
                end else if (timeoutHit) begin
                    if (attempt < AttemptWidth'(RETRIES)) begin
                        nextState = SEND;
                        shiftNext = snapFrame;
                    end else begin
                        nextState = FAIL;
                    end
                end
            end
            DONE:    nextState = IDLE;
            FAIL:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Snapshot, bit/wait/attempt counters and the last reported vector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shiftReg   <= '0;
            snapFrame  <= '0;
            bitCnt     <= '0;
            waitCnt    <= '0;
            attempt    <= '0;
            lastVector <= '0;
        end else begin
            shiftReg <= shiftNext;
            case (state)
                IDLE: begin
                    if (nextState == SEND) begin
                        snapFrame <= liveFrame;
                        attempt   <= '0;
                        bitCnt    <= '0;
                    end
                end
                SEND: begin
                    if (bitCnt == 5'd23) begin
                        bitCnt  <= '0;
                        waitCnt <= '0;
                    end else begin
                        bitCnt <= bitCnt + 5'd1;
                    end
                end
                WAIT_ACK: begin
                    if (nextState == SEND) begin
                        attempt <= attempt + AttemptWidth'(1);
                        waitCnt <= '0;
                    end else if (!bus.txConfirm) begin
                        waitCnt <= waitCnt + WaitWidth'(1);
                    end
                end
                DONE:    lastVector <= snapFrame[23:18];
                FAIL:    lastVector <= snapFrame[23:18];
                default: ;
            endcase
        end
    end

    // Registered outputs, derived from the state being entered on this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.txRequest <= 1'b0;
            bus.txData    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.frameSent <= 1'b0;
            bus.linkFail  <= 1'b0;
        end else begin
            bus.txRequest <= (nextState == SEND);
            bus.txData    <= (nextState == SEND) && shiftNext[23];
            bus.busy      <= (nextState != IDLE);
            bus.frameSent <= (nextState == DONE);
            if (nextState == FAIL) begin
                bus.linkFail <= 1'b1;
            end else if (nextState == DONE) begin
                bus.linkFail <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_abnormality_report_tx.sv
// tb/tb_abnormality_report_tx.sv - randomized self-checking bench for abnormality_report_tx
module tb_abnormality_report_tx;
    localparam int TIMEOUT = 16;
    localparam int RETRIES = 2;

    logic       clock;
    logic       reset;
    int         nChecks = 0;
    int         nPass   = 0;
    logic [5:0] modelLast;

    abnormality_report_tx_if bus ();

    abnormality_report_tx #(.TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Frame as a number: fields weighted by their bit positions, parity from the ones count.
    function automatic logic [23:0] make_frame(input logic [5:0] v, input logic [2:0] w,
                                               input logic [6:0] p, input logic [6:0] q);
        int body;
        body = int'(v) * 262144 + int'(w) * 32768 + int'(p) * 256 + int'(q) * 2;
        return 24'(body + ($countones(body) % 2));
    endfunction

    function automatic logic [5:0] pick_new_vector();
        logic [5:0] v;
        do v = 6'($urandom); while (v == modelLast || v == 6'd0);
        return v;
    endfunction

    task automatic randomize_side_fields();
        bus.abnormaliryWarning = 3'($urandom);
        bus.dataP              = 7'($urandom);
        bus.dataQ              = 7'($urandom);
    endtask

    // Waits for txRequest, then collects 24 bits on falling edges; ends after the last bit.
    task automatic capture_frame(input int budget, input int changeAt, input logic [5:0] newVec,
                                 output logic [23:0] f, output int waited, output bit ok);
        bit held;
        f = '0; waited = 0; ok = 1'b0; held = 1'b1;
        do begin
            @(negedge clock);
            waited++;
        end while (bus.txRequest !== 1'b1 && waited < budget);
        if (bus.txRequest === 1'b1) begin
            for (int k = 0; k < 24; k++) begin
                if (k > 0) @(negedge clock);
                if (bus.txRequest !== 1'b1) held = 1'b0;
                f = {f[22:0], bus.txData};
                if (k == changeAt) bus.abnormaliryVector = newVec;
            end
            ok = held;
        end
    endtask

    // Raises txConfirm so that it is sampled j edges after the last bit; ends in the DONE cycle.
    task automatic ack_at(input int j, output bit reqSeen);
        reqSeen = 1'b0;
        repeat (j) begin
            @(negedge clock);
            if (bus.txRequest !== 1'b0) reqSeen = 1'b1;
        end
        bus.txConfirm = 1'b1;
        @(negedge clock);
        bus.txConfirm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.abnormaliryVector  = '0;
        bus.abnormaliryWarning = '0;
        bus.dataP              = '0;
        bus.dataQ              = '0;
        bus.txConfirm          = 1'b0;
        repeat (3) @(negedge clock);
        nChecks++;
        if ({bus.txRequest, bus.txData, bus.busy, bus.frameSent, bus.linkFail} !== 5'b0)
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus.txRequest, bus.txData, bus.busy, bus.frameSent, bus.linkFail});
        else nPass++;
        reset = 1'b0;
        modelLast = '0;
        repeat (3) @(negedge clock);
        nChecks++;
        if ({bus.busy, bus.txRequest} !== 2'b00)
            $display("FAIL reset_idle got=%b exp=00", {bus.busy, bus.txRequest});
        else nPass++;
    endtask

    task automatic test_basic_delivery();
        logic [23:0] f, exp;
        int waited, seen;
        bit ok, reqSeen;
        bus.abnormaliryVector  = 6'b000110;
        bus.abnormaliryWarning = 3'b010;
        bus.dataP              = 7'h0F;
        bus.dataQ              = 7'h00;
        exp = make_frame(6'b000110, 3'b010, 7'h0F, 7'h00);
        capture_frame(5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || waited != 1) $display("FAIL basic_start ok=%0d waited=%0d exp ok=1 waited=1", ok, waited);
        else nPass++;
        nChecks++;
        if (f !== exp) $display("FAIL basic_frame_model got=%h exp=%h", f, exp);
        else nPass++;
        nChecks++;
        if (f !== 24'h190F01) $display("FAIL basic_frame_known got=%h exp=190f01", f);
        else nPass++;
        ack_at(3, reqSeen);
        nChecks++;
        if (reqSeen) $display("FAIL basic_req_in_wait got=1 exp=0");
        else nPass++;
        nChecks++;
        if ({bus.frameSent, bus.busy, bus.linkFail} !== 3'b110)
            $display("FAIL basic_done got=%b exp=110", {bus.frameSent, bus.busy, bus.linkFail});
        else nPass++;
        @(negedge clock);
        nChecks++;
        if ({bus.frameSent, bus.busy} !== 2'b00)
            $display("FAIL basic_after_done got=%b exp=00", {bus.frameSent, bus.busy});
        else nPass++;
        modelLast = 6'b000110;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.txRequest !== 1'b0 || bus.frameSent !== 1'b0) seen++;
        end
        nChecks++;
        if (seen != 0) $display("FAIL basic_no_second_frame active_cycles=%0d exp=0", seen);
        else nPass++;
    endtask

    task automatic test_no_change();
        int seen;
        reset = 1'b1;
        bus.abnormaliryVector = '0;
        @(negedge clock);
        reset = 1'b0;
        modelLast = '0;
        seen = 0;
        repeat (100) begin
            @(negedge clock);
            randomize_side_fields();
            if (bus.txRequest !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        nChecks++;
        if (seen != 0) $display("FAIL no_change_quiet active_cycles=%0d exp=0", seen);
        else nPass++;
    endtask

    task automatic test_retry();
        logic [23:0] f, exp;
        logic [5:0] v;
        int waited, pulses;
        bit ok, reqSeen;
        v = pick_new_vector();
        randomize_side_fields();
        bus.abnormaliryVector = v;
        exp = make_frame(v, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        capture_frame(5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || waited != 1 || f !== exp)
            $display("FAIL retry_first got=%h waited=%0d ok=%0d exp=%h waited=1", f, waited, ok, exp);
        else nPass++;
        randomize_side_fields();
        capture_frame(TIMEOUT + 5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || waited != TIMEOUT + 1)
            $display("FAIL retry_restart_time waited=%0d ok=%0d exp waited=%0d", waited, ok, TIMEOUT + 1);
        else nPass++;
        nChecks++;
        if (f !== exp) $display("FAIL retry_snapshot got=%h exp=%h", f, exp);
        else nPass++;
        ack_at(int'($urandom_range(TIMEOUT, 1)), reqSeen);
        nChecks++;
        if ({bus.frameSent, bus.linkFail, reqSeen} !== 3'b100)
            $display("FAIL retry_done got=%b exp=100", {bus.frameSent, bus.linkFail, reqSeen});
        else nPass++;
        modelLast = v;
        pulses = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.frameSent !== 1'b0 || bus.txRequest !== 1'b0) pulses++;
        end
        nChecks++;
        if (pulses != 0) $display("FAIL retry_single_delivery extra_cycles=%0d exp=0", pulses);
        else nPass++;
    endtask

    task automatic test_exhaustion();
        logic [23:0] f, exp;
        logic [5:0] v;
        int waited, seen;
        bit ok, reqSeen;
        v = pick_new_vector();
        randomize_side_fields();
        bus.abnormaliryVector = v;
        exp = make_frame(v, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        for (int a = 0; a <= RETRIES; a++) begin
            capture_frame(TIMEOUT + 5, -1, 6'd0, f, waited, ok);
            nChecks++;
            if (!ok || f !== exp || waited != (a == 0 ? 1 : TIMEOUT + 1))
                $display("FAIL exhaust_attempt%0d got=%h waited=%0d ok=%0d exp=%h", a, f, waited, ok, exp);
            else nPass++;
        end
        seen = 0;
        repeat (TIMEOUT + 1) begin
            @(negedge clock);
            if (bus.txRequest !== 1'b0) seen++;
        end
        nChecks++;
        if (bus.linkFail !== 1'b1 || seen != 0)
            $display("FAIL exhaust_link_fail got=%b req_cycles=%0d exp=1 req_cycles=0", bus.linkFail, seen);
        else nPass++;
        repeat (5) @(negedge clock);
        nChecks++;
        if ({bus.busy, bus.linkFail, bus.txRequest} !== 3'b010)
            $display("FAIL exhaust_idle got=%b exp=010", {bus.busy, bus.linkFail, bus.txRequest});
        else nPass++;
        modelLast = v;
        v = (modelLast == 6'h2A) ? 6'h15 : 6'h2A;
        bus.abnormaliryVector = v;
        exp = make_frame(v, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        capture_frame(5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || f !== exp) $display("FAIL exhaust_followup_frame got=%h exp=%h", f, exp);
        else nPass++;
        ack_at(int'($urandom_range(TIMEOUT, 1)), reqSeen);
        nChecks++;
        if ({bus.frameSent, bus.linkFail} !== 2'b10)
            $display("FAIL exhaust_recover got=%b exp=10", {bus.frameSent, bus.linkFail});
        else nPass++;
        @(negedge clock);
        modelLast = v;
    endtask

    task automatic test_midframe_change();
        logic [23:0] f, exp1, exp3;
        int waited;
        bit ok, reqSeen;
        randomize_side_fields();
        bus.abnormaliryVector = 6'd1;
        exp1 = make_frame(6'd1, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        exp3 = make_frame(6'd3, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        bus.txConfirm = 1'b1;
        capture_frame(5, 10, 6'd3, f, waited, ok);
        bus.txConfirm = 1'b0;
        nChecks++;
        if (!ok || f !== exp1) $display("FAIL mid_first_frame got=%h ok=%0d exp=%h", f, ok, exp1);
        else nPass++;
        ack_at(2, reqSeen);
        nChecks++;
        if (bus.frameSent !== 1'b1) $display("FAIL mid_first_done got=%b exp=1", bus.frameSent);
        else nPass++;
        capture_frame(5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || waited != 2) $display("FAIL mid_gap waited=%0d ok=%0d exp waited=2", waited, ok);
        else nPass++;
        nChecks++;
        if (f !== exp3) $display("FAIL mid_second_frame got=%h exp=%h", f, exp3);
        else nPass++;
        ack_at(1, reqSeen);
        @(negedge clock);
        modelLast = 6'd3;
    endtask

    task automatic test_reset_mid_send();
        logic [23:0] f, exp;
        logic [5:0] v;
        int waited;
        bit ok, reqSeen;
        v = pick_new_vector();
        randomize_side_fields();
        bus.abnormaliryVector = v;
        exp = make_frame(v, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (bus.txRequest !== 1'b1 && waited < 5);
        nChecks++;
        if (bus.txRequest !== 1'b1) $display("FAIL rst_send_start got=%b exp=1", bus.txRequest);
        else nPass++;
        repeat (5) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        nChecks++;
        if ({bus.txRequest, bus.txData, bus.busy} !== 3'b000)
            $display("FAIL rst_send_immediate got=%b exp=000", {bus.txRequest, bus.txData, bus.busy});
        else nPass++;
        @(negedge clock);
        reset = 1'b0;
        modelLast = '0;
        capture_frame(5, -1, 6'd0, f, waited, ok);
        nChecks++;
        if (!ok || waited != 1 || f !== exp)
            $display("FAIL rst_send_fresh got=%h waited=%0d ok=%0d exp=%h waited=1", f, waited, ok, exp);
        else nPass++;
        ack_at(1, reqSeen);
        @(negedge clock);
        modelLast = v;
    endtask

    task automatic test_random();
        logic [23:0] f, exp;
        logic [5:0] v;
        int waited, seen;
        bit ok, reqSeen;
        for (int it = 0; it < 10; it++) begin
            v = ($urandom_range(3, 0) == 0) ? modelLast : pick_new_vector();
            randomize_side_fields();
            bus.abnormaliryVector = v;
            if (v == modelLast) begin
                seen = 0;
                repeat (12) begin
                    @(negedge clock);
                    if (bus.txRequest !== 1'b0) seen++;
                end
                nChecks++;
                if (seen != 0) $display("FAIL rand_idle it=%0d req_cycles=%0d exp=0", it, seen);
                else nPass++;
            end else begin
                exp = make_frame(v, bus.abnormaliryWarning, bus.dataP, bus.dataQ);
                capture_frame(5, -1, 6'd0, f, waited, ok);
                nChecks++;
                if (!ok || waited != 1 || f !== exp)
                    $display("FAIL rand_frame it=%0d got=%h waited=%0d exp=%h", it, f, waited, exp);
                else nPass++;
                ack_at(int'($urandom_range(TIMEOUT, 1)), reqSeen);
                nChecks++;
                if ({bus.frameSent, bus.linkFail, reqSeen} !== 3'b100)
                    $display("FAIL rand_done it=%0d got=%b exp=100", it,
                             {bus.frameSent, bus.linkFail, reqSeen});
                else nPass++;
                @(negedge clock);
                modelLast = v;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_delivery();
        test_no_change();
        test_retry();
        test_exhaustion();
        test_midframe_change();
        test_reset_mid_send();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/abnormality_report_tx.md
# abnormality_report_tx

- Downstream stage of `LogicHealthcareSystem`.
- Watches the system's abnormality outputs (`abnormaliryVector`, `abnormaliryWarning`) and its encrypted data halves (`dataP`, `dataQ`).
- Whenever the abnormality vector differs from the last value reported, it snapshots these outputs into a 24-bit parity-protected frame.
- It shifts the frame out serially under a request/confirm handshake, then waits for the receiver's confirm.
- On a missing confirm it retransmits a bounded number of times, then flags a link failure.

## Interface
- `TIMEOUT`, 16: WAIT_ACK cycles allowed for `txConfirm` per attempt (≥1).
- `RETRIES`, 2: retransmissions after the first attempt (total attempts = `RETRIES`+1).
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `abnormaliryVector` in 6: per-channel abnormality flags from `LogicHealthcareSystem`.
- `abnormaliryWarning` in 3: warning level from `LogicHealthcareSystem`.
- `dataP` in 7: encrypted data, upper half.
- `dataQ` in 7: encrypted data, lower half.
- `txConfirm` in 1: receiver acknowledge, sampled only in WAIT_ACK.
- `txRequest` out 1: high for exactly the 24 bit-cycles of a frame.
- `txData` out 1: serial frame bit, MSB first; 0 when `txRequest`=0.
- `busy` out 1: high in every state except IDLE.
- `frameSent` out 1: one-cycle pulse on confirmed delivery.
- `linkFail` out 1: sticky; set on exhaustion of all attempts, cleared on the next confirmed frame.

## Operation
- Frame layout, bit 23 down to 0: `[23:18]` vector, `[17:15]` warning, `[14:8]` dataP, `[7:1]` dataQ, `[0]` even parity.
  - The parity bit makes the XOR of all 24 bits equal to 0.
- Internal `lastVector` register; reset value 6'b0.
- States:
  - IDLE: if `abnormaliryVector` != `lastVector` at a clock edge, load the frame into the shift register, set attempt=0 and bitCnt=0, and go to SEND.
  - SEND:
    - `txRequest`=1 and `txData`=shift[23].
    - Each edge shifts left and increments bitCnt.
    - The edge with bitCnt=23 moves to WAIT_ACK and clears waitCnt.
  - WAIT_ACK:
    - `txRequest`=0.
    - `txConfirm` sampled high → DONE.
    - Otherwise waitCnt++. When TIMEOUT edges have passed without confirm:
      - if attempt<RETRIES: attempt++, reload the shift register from the held snapshot (not the live inputs), go to SEND;
      - else go to FAIL.
  - DONE: `lastVector`←snapshot vector, `frameSent`=1, clear `linkFail`, go to IDLE.
  - FAIL: `lastVector`←snapshot vector (frame dropped, no endless loop), set `linkFail`, go to IDLE.
- Input changes during SEND, WAIT_ACK, DONE or FAIL are ignored. After returning to IDLE, the live vector is compared against the reported snapshot; a difference starts a new frame on the next edge.
- `txConfirm` outside WAIT_ACK is ignored; it never shortens or aborts SEND.
- Comparison covers the vector only. A change in warning or data alone does not trigger a frame.

## Timing
- Reset (async, immediate) values:
  - state=IDLE;
  - `txRequest`, `txData`, `busy`, `frameSent`, `linkFail` = 0;
  - `lastVector`=0, counters=0.
- Reset mid-frame aborts on the spot: outputs drop low without waiting for a clock edge.
- All outputs are registered.
- Capture edge E0 (IDLE, mismatch):
  - after E0, `txRequest`=1, `txData`=bit23;
  - after E0+k, `txData`=bit(23−k) for k=0..23;
  - after E24, `txRequest`=0 (WAIT_ACK).
- Confirm sampled at E24+j (1≤j≤TIMEOUT) → DONE after that edge; `frameSent` high during the following cycle; `busy` falls with it (IDLE next edge).
- No confirm by E24+TIMEOUT → the retry's first bit is driven after that edge.
- A nonzero vector present at reset release triggers a frame on the first edge.
- Back-to-back frames: minimum gap is one IDLE cycle after DONE.

## Test plan
- Basic delivery:
  - Stimulus: vector=6'b000110, warning=3'b010, dataP=7'h0F, dataQ=7'h00; `txConfirm` pulsed at E24+3.
  - Required: serial stream = 24'h190F01 MSB first; `frameSent` one cycle; `busy` 0 afterwards; no second frame.
- No change:
  - Stimulus: vector held at 0 after reset for 100 cycles; warning and data toggling.
  - Required: `txRequest` stays 0 throughout.
- Retry then success (TIMEOUT=16, RETRIES=2):
  - Stimulus: no confirm on the first attempt; confirm on the second.
  - Required: two identical 24-bit frames; second SEND starts after E24+16; `frameSent` once; `linkFail`=0.
- Exhaustion:
  - Stimulus: never confirm.
  - Required: exactly 3 frames, then `linkFail`=1 and IDLE.
  - Follow-up: change vector and confirm the next frame → `linkFail` clears with `frameSent`.
- Mid-frame input change:
  - Stimulus: vector 1→3 at bit 10 of a frame; confirm.
  - Required: first frame carries 1; a second frame carrying 3 starts one cycle after DONE.
- Reset mid-SEND:
  - Stimulus: assert `reset` between edges during bit 5.
  - Required: `txRequest`/`txData` go 0 immediately.
  - After release with a nonzero vector: a fresh complete frame starts from bit 23.
